ahb_lite_sram_ctrl: RTL and testbench

AHB-Lite slave wrapping an internal single-port, byte-lane-writable word SRAM.
- Parametrised depth and programmable data-phase wait states.
- Two-cycle ERROR response for illegal or out-of-range transfers.
- Posted-write buffer with read-merge forwarding, so back-to-back write→read of the same word needs no stall.
- Sits on the AHB matrix as a general-purpose data/scratch memory.

---
 rtl/ahb_lite_sram_ctrl_if.sv | 17 +
 rtl/ahb_lite_sram_ctrl.sv | 91 +++++++++
 tb/tb_ahb_lite_sram_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_sram_ctrl_if.sv
// ahb_lite_sram_ctrl_if: AHB-Lite bus bundle between a master and the SRAM slave
interface ahb_lite_sram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  modport master (output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
                  input HREADYOUT, HRDATA, HRESP);
  modport slave (input HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
                 output HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/ahb_lite_sram_ctrl.sv
// ahb_lite_sram_ctrl: AHB-Lite SRAM slave with wait states, ERROR responses and a forwarding posted-write buffer
module ahb_lite_sram_ctrl #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DEPTH_WORDS      = 2**(ADDR_WIDTH-2),
  parameter int WAIT_STATES      = 0,
  parameter bit ERR_ON_UNALIGNED = 1'b1
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_lite_sram_ctrl_if.slave ahb
);
  localparam int IW = ADDR_WIDTH-2;
  localparam int MW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] widx, dp_idx, buf_idx;
  logic [3:0] lanes, dp_lanes, buf_lanes;
  logic [31:0] buf_data, rd_merge, hrdata;
  logic dp_v, dp_write, buf_v, acc, bad, acc_ok, fin, ld, rd_issue, commit;
  assign widx = ahb.HADDR[ADDR_WIDTH-1:2];
  assign acc = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign lanes = ahb.HSIZE == 3'd0 ? 4'b0001 << ahb.HADDR[1:0] :
                 ahb.HSIZE == 3'd1 ? (ahb.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bad = (ahb.HSIZE > 3'd2)
             | (ERR_ON_UNALIGNED & ((ahb.HSIZE == 3'd1 & ahb.HADDR[0]) | (ahb.HSIZE == 3'd2 & |ahb.HADDR[1:0])))
             | (32'(widx) >= 32'(DEPTH_WORDS));
  assign acc_ok = acc & ~bad;
  assign fin = dp_v & (state == IDLE);
  assign ld = fin & dp_write;
  assign rd_issue = acc_ok & ~ahb.HWRITE;
  // the old entry is pushed out whenever a new write reloads the buffer, even alongside a read
  assign commit = buf_v & (ld | ~rd_issue);
  assign ahb.HREADYOUT = ~(state == WAIT || state == ERR1);
  assign ahb.HRESP = state == ERR1 || state == ERR2;
  assign ahb.HRDATA = hrdata;
  always_comb begin
    rd_merge = mem[widx[MW-1:0]];
    for (int i = 0; i < 4; i++) begin
      if (buf_v && buf_idx == widx && buf_lanes[i]) rd_merge[8*i +: 8] = buf_data[8*i +: 8];
      if (ld && dp_idx == widx && dp_lanes[i]) rd_merge[8*i +: 8] = ahb.HWDATA[8*i +: 8];
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == WAIT) begin
      state_n = cnt == 3'd1 ? IDLE : WAIT;
      cnt_n = cnt - 3'd1;
    end else if (state == ERR1) begin
      state_n = ERR2;
    end else begin
      state_n = !acc ? IDLE : bad ? ERR1 : (WAIT_STATES > 0 ? WAIT : IDLE);
      cnt_n = acc_ok ? 3'(WAIT_STATES) : cnt;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      cnt <= '0;
      dp_v <= 1'b0;
      dp_write <= 1'b0;
      dp_idx <= '0;
      dp_lanes <= '0;
      buf_v <= 1'b0;
      buf_idx <= '0;
      buf_lanes <= '0;
      buf_data <= '0;
      hrdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dp_v <= acc_ok | (dp_v & ~fin);
      if (acc_ok) begin
        dp_write <= ahb.HWRITE;
        dp_idx <= widx;
        dp_lanes <= lanes;
      end
      buf_v <= ld | (buf_v & ~commit);
      if (ld) begin
        buf_idx <= dp_idx;
        buf_lanes <= dp_lanes;
        buf_data <= ahb.HWDATA;
      end
      if (rd_issue) hrdata <= rd_merge;
    end
  always_ff @(posedge HCLK)
    for (int i = 0; i < 4; i++)
      if (commit && buf_lanes[i]) mem[buf_idx[MW-1:0]][8*i +: 8] <= buf_data[8*i +: 8];
endmodule

// File: tb/tb_ahb_lite_sram_ctrl.sv
// tb_ahb_lite_sram_ctrl: table-driven AHB transfers against zero- and three-wait-state instances
module tb_ahb_lite_sram_ctrl;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;
  logic sel, hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  logic [2:0] hsize;
  ahb_lite_sram_ctrl_if b0();
  ahb_lite_sram_ctrl_if b3();
  assign b0.HSEL = hsel & ~sel;
  assign b3.HSEL = hsel & sel;
  assign b0.HADDR = haddr;
  assign b3.HADDR = haddr;
  assign b0.HTRANS = htrans;
  assign b3.HTRANS = htrans;
  assign b0.HSIZE = hsize;
  assign b3.HSIZE = hsize;
  assign b0.HWRITE = hwrite;
  assign b3.HWRITE = hwrite;
  assign b0.HWDATA = hwdata;
  assign b3.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b3.HREADY = b3.HREADYOUT;
  ahb_lite_sram_ctrl #(.DEPTH_WORDS(64)) u0 (.HCLK(HCLK), .HRESETn(HRESETn), .ahb(b0.slave));
  ahb_lite_sram_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u3 (.HCLK(HCLK), .HRESETn(HRESETn), .ahb(b3.slave));
  wire rdy = sel ? b3.HREADYOUT : b0.HREADYOUT;
  wire resp = sel ? b3.HRESP : b0.HRESP;
  wire [31:0] rdata = sel ? b3.HRDATA : b0.HRDATA;
  typedef struct {
    logic w; logic [31:0] a; logic [2:0] sz; logic [31:0] d; logic err; logic [31:0] exp; int gap; int id;
  } vec_t;
  typedef struct {
    int sel; int id; logic w; logic err; logic [31:0] d; logic [31:0] exp; int waits;
  } exp_t;
  vec_t va[19];
  vec_t vb[6];
  vec_t tq[$];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask
  task automatic run();
    int guard = 0;
    int waits = 0;
    logic wresp = 1'b0;
    exp_t e;
    while ((tq.size() > 0 || sb.size() > 0) && guard < 500) begin
      vec_t v;
      bit drv;
      guard++;
      drv = 0;
      hsel = 1'b0;
      htrans = 2'b00;
      if (tq.size() > 0) begin
        v = tq[0];
        if (v.gap > 0) begin
          v.gap--;
          tq[0] = v;
        end else begin
          drv = 1;
          hsel = 1'b1;
          htrans = 2'b10;
          haddr = v.a;
          hsize = v.sz;
          hwrite = v.w;
        end
      end
      hwdata = sb.size() > 0 ? sb[0].d : 32'h0;
      @(negedge HCLK);
      if (sb.size() > 0) begin
        if (!rdy) begin
          waits++;
          wresp = resp;
        end else begin
          e = sb.pop_front();
          chk($sformatf("s%0d#%0d waits", e.sel, e.id), 32'(waits), 32'(e.waits));
          chk($sformatf("s%0d#%0d resp", e.sel, e.id), 32'(resp), 32'(e.err));
          if (e.err) chk($sformatf("s%0d#%0d err1_resp", e.sel, e.id), 32'(wresp), 32'd1);
          else if (!e.w) chk($sformatf("s%0d#%0d rdata", e.sel, e.id), rdata, e.exp);
          waits = 0;
          wresp = 1'b0;
        end
      end
      if (drv && rdy) begin
        void'(tq.pop_front());
        sb.push_back('{sel: int'(sel), id: v.id, w: v.w, err: v.err, d: v.d, exp: v.exp,
                       waits: v.err ? 1 : (sel ? 3 : 0)});
      end
      @(posedge HCLK);
      #1;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL run_timeout pending %0d queued %0d", sb.size(), tq.size());
      tq.delete();
      sb.delete();
    end
  endtask
  initial begin
    va = '{
      '{1, 32'h10,  2, 32'hDEADBEEF, 0, 32'h0,        0, 0},
      '{0, 32'h10,  2, 32'h0,        0, 32'hDEADBEEF, 2, 0},
      '{1, 32'h20,  2, 32'h11223344, 0, 32'h0,        0, 0},
      '{1, 32'h22,  0, 32'h00AA0000, 0, 32'h0,        0, 0},
      '{0, 32'h20,  2, 32'h0,        0, 32'h11AA3344, 0, 0},
      '{1, 32'h04,  2, 32'h01020304, 0, 32'h0,        0, 0},
      '{1, 32'h06,  2, 32'hFFFFFFFF, 1, 32'h0,        0, 0},
      '{0, 32'h04,  2, 32'h0,        0, 32'h01020304, 0, 0},
      '{1, 32'h00,  2, 32'hA0A0A0A0, 0, 32'h0,        0, 0},
      '{1, 32'h100, 2, 32'hFFFFFFFF, 1, 32'h0,        0, 0},
      '{0, 32'h00,  2, 32'h0,        0, 32'hA0A0A0A0, 0, 0},
      '{1, 32'h40,  3, 32'hFFFFFFFF, 1, 32'h0,        0, 0},
      '{1, 32'h40,  2, 32'h5A5A5A5A, 0, 32'h0,        0, 0},
      '{1, 32'h42,  1, 32'hBEEF0000, 0, 32'h0,        0, 0},
      '{0, 32'h40,  2, 32'h0,        0, 32'hBEEF5A5A, 0, 0},
      '{1, 32'h41,  1, 32'hFFFFFFFF, 1, 32'h0,        0, 0},
      '{1, 32'h43,  0, 32'h77000000, 0, 32'h0,        0, 0},
      '{0, 32'h40,  2, 32'h0,        0, 32'h77EF5A5A, 0, 0},
      '{0, 32'h10,  2, 32'h0,        0, 32'hDEADBEEF, 0, 0}
    };
    vb = '{
      '{1, 32'h04, 2, 32'h87654321, 0, 32'h0,        0, 0},
      '{0, 32'h04, 2, 32'h0,        0, 32'h87654321, 0, 0},
      '{1, 32'h08, 2, 32'h11111111, 0, 32'h0,        0, 0},
      '{0, 32'h08, 2, 32'h0,        0, 32'h11111111, 0, 0},
      '{1, 32'h06, 2, 32'hFFFFFFFF, 1, 32'h0,        0, 0},
      '{0, 32'h04, 2, 32'h0,        0, 32'h87654321, 0, 0}
    };
    sel = 1'b0;
    hsel = 1'b0;
    htrans = 2'b00;
    haddr = 32'h0;
    hsize = 3'd2;
    hwrite = 1'b0;
    hwdata = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst0_ready", 32'(b0.HREADYOUT), 32'd1);
    chk("rst0_resp", 32'(b0.HRESP), 32'd0);
    chk("rst0_rdata", b0.HRDATA, 32'h0);
    chk("rst3_ready", 32'(b3.HREADYOUT), 32'd1);
    chk("rst3_resp", 32'(b3.HRESP), 32'd0);
    chk("rst3_rdata", b3.HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    for (int i = 0; i < 19; i++) begin
      va[i].id = i;
      tq.push_back(va[i]);
    end
    run();
    sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vb[i].id = i;
      tq.push_back(vb[i]);
    end
    run();
    hsel = 1'b1;
    htrans = 2'b10;
    haddr = 32'h8;
    hsize = 3'd2;
    hwrite = 1'b1;
    @(posedge HCLK);
    #1;
    hsel = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h22222222;
    @(negedge HCLK);
    chk("abort_wait_ready", 32'(rdy), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy), 32'd1);
    chk("abort_resp", 32'(resp), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    tq.push_back('{w: 1'b0, a: 32'h8, sz: 3'd2, d: 32'h0, err: 1'b0, exp: 32'h11111111, gap: 1, id: 99});
    run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
